// File: rtl/sum_matrix_loop_ctrl.sv
// sum_matrix_loop_ctrl: sequencer for the flattened row x column loop nest of the sum_matrix kernel.
// The loop runs at II=1 through a DEPTH-stage datapath pipeline.
// Ports:
//   ap_clk, ap_rst_n              clock, synchronous active-low reset
//   ap_start/ap_ready/ap_done/ap_idle  ap_ctrl_hs handshake
//   num_rows, num_cols            trip counts, latched when start is accepted
//   stall                         datapath backpressure; freezes pipeline, indices and count
//   row_idx, col_idx              registered indices of the issuing iteration
//   issue_valid, first_iter, last_iter  issue qualifiers for stage 0
//   en_chain                      per-stage valid bits (bit 0 is the issuing iteration)
//   retire_valid, iter_count      retirement strobe and running count of retired iterations
module sum_matrix_loop_ctrl #(
    parameter int ROWS_W = 16,
    parameter int COLS_W = 16,
    parameter int DEPTH  = 20
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_ready,
    output logic              ap_done,
    output logic              ap_idle,
    input  logic [ROWS_W-1:0] num_rows,
    input  logic [COLS_W-1:0] num_cols,
    input  logic              stall,
    output logic [ROWS_W-1:0] row_idx,
    output logic [COLS_W-1:0] col_idx,
    output logic              issue_valid,
    output logic              first_iter,
    output logic              last_iter,
    output logic [DEPTH-1:0]  en_chain,
    output logic              retire_valid,
    output logic [31:0]       iter_count
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t            state, state_nx;
    logic [ROWS_W-1:0] rows_q;
    logic [COLS_W-1:0] cols_q;
    // stage 0 is the issue cycle itself, so only stages 1..DEPTH-1 are registered
    logic [DEPTH-1:1]  stage_q;
    logic              row_end, col_end;

    always_comb begin
        row_end      = row_idx == rows_q - ROWS_W'(1);
        col_end      = col_idx == cols_q - COLS_W'(1);
        issue_valid  = (state == RUN) && !stall;
        en_chain     = {stage_q, issue_valid};
        retire_valid = en_chain[DEPTH-1] && !stall;
        first_iter   = issue_valid && row_idx == '0 && col_idx == '0;
        last_iter    = issue_valid && row_end && col_end;
        ap_idle      = state == IDLE;
        ap_done      = state == DONE;
        // zero-dimension launches never issue, so ready coincides with done
        ap_ready     = last_iter || (ap_done && (rows_q == '0 || cols_q == '0));
        state_nx     = state;
        case (state)
            IDLE:    state_nx = !ap_start ? IDLE : (num_rows == '0 || num_cols == '0) ? DONE : RUN;
            RUN:     state_nx = last_iter ? DRAIN : RUN;
            DRAIN:   state_nx = (retire_valid && en_chain[DEPTH-2:0] == '0) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state      <= IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            stage_q    <= '0;
            row_idx    <= '0;
            col_idx    <= '0;
            iter_count <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && ap_start) begin
                rows_q     <= num_rows;
                cols_q     <= num_cols;
                row_idx    <= '0;
                col_idx    <= '0;
                iter_count <= '0;
            end
            if (!stall)
                stage_q <= en_chain[DEPTH-2:0];
            if (issue_valid) begin
                col_idx <= col_end ? '0 : col_idx + COLS_W'(1);
                if (col_end)
                    row_idx <= row_idx + ROWS_W'(1);
            end
            if (retire_valid)
                iter_count <= iter_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_sum_matrix_loop_ctrl.sv
// tb_sum_matrix_loop_ctrl: scoreboard bench for sum_matrix_loop_ctrl.
// Ports: none (drives every DUT port, generates ap_clk).
module tb_sum_matrix_loop_ctrl;
    localparam int DEPTH = 20;

    typedef struct {int r; int c; bit f; bit l;} iss_t;
    typedef struct {int n; bit z; int acc; bit b2b;} done_t;

    logic        ap_clk = 1'b0, ap_rst_n = 1'b0, ap_start = 1'b0, stall = 1'b0;
    logic [15:0] num_rows = '0, num_cols = '0;
    logic        ap_ready, ap_done, ap_idle, issue_valid, first_iter, last_iter, retire_valid;
    logic [15:0] row_idx, col_idx;
    logic [DEPTH-1:0] en_chain;
    logic [31:0] iter_count;

    sum_matrix_loop_ctrl #(.ROWS_W(16), .COLS_W(16), .DEPTH(DEPTH)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_idle(ap_idle), .num_rows(num_rows), .num_cols(num_cols),
        .stall(stall), .row_idx(row_idx), .col_idx(col_idx), .issue_valid(issue_valid),
        .first_iter(first_iter), .last_iter(last_iter), .en_chain(en_chain),
        .retire_valid(retire_valid), .iter_count(iter_count)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    iss_t  iq[$];
    done_t dq[$];
    int    total = 0, bad = 0, stim_to = 0;
    bit    stall_en = 0, finished = 0;

    // Expected behaviour of one accepted launch: every (row, col) in row-major order,
    // then one completion carrying the iteration count.
    function automatic void push_model(int r, int c, bit b2b);
        for (int i = 0; i < r; i++)
            for (int j = 0; j < c; j++)
                iq.push_back('{i, j, i == 0 && j == 0, i == r - 1 && j == c - 1});
        dq.push_back('{r * c, r == 0 || c == 0, cyc, b2b});
    endfunction

    task automatic chk(input string n, input longint a, input longint e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
        end
    endtask

    int    stalls = 0, retired = 0, last_done = -100;
    bit    rst_seen = 0, expect_idle = 0;
    iss_t  ei;
    done_t ed;

    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            rst_seen    = 1;
            stalls      = 0;
            retired     = 0;
            expect_idle = 0;
        end else begin
            if (rst_seen) begin
                chk("rst_idle", ap_idle, 1);
                chk("rst_en_chain", en_chain, 0);
                chk("rst_done", ap_done, 0);
                chk("rst_ready", ap_ready, 0);
                chk("rst_iter_count", iter_count, 0);
                chk("rst_row", row_idx, 0);
                chk("rst_col", col_idx, 0);
                rst_seen = 0;
            end
            if (expect_idle) begin
                chk("idle_after_done", ap_idle, 1);
                expect_idle = 0;
            end
            if (issue_valid) begin
                if (iq.size() == 0) chk("issue_unexpected", issue_valid, 0);
                else begin
                    ei = iq.pop_front();
                    chk("row_idx", row_idx, ei.r);
                    chk("col_idx", col_idx, ei.c);
                    chk("first_iter", first_iter, ei.f);
                    chk("last_iter", last_iter, ei.l);
                    chk("ready_at_issue", ap_ready, ei.l);
                    if (ei.f && dq.size() > 0) chk("first_issue_cycle", cyc, dq[0].acc + 1 + stalls);
                end
            end else if (!ap_done)
                chk("ready_spurious", ap_ready, 0);
            if (retire_valid) retired++;
            if (ap_done) begin
                if (dq.size() == 0) chk("done_unexpected", ap_done, 0);
                else begin
                    ed = dq.pop_front();
                    chk("iter_count", iter_count, ed.n);
                    chk("retired", retired, ed.n);
                    chk("ready_with_done", ap_ready, ed.z);
                    chk("done_latency", cyc - ed.acc, ed.z ? 1 : ed.n + DEPTH + stalls);
                    if (ed.b2b) chk("b2b_accept", ed.acc, last_done + 1);
                end
                last_done   = cyc;
                retired     = 0;
                stalls      = 0;
                expect_idle = 1;
            end else if (dq.size() > 0 && cyc > dq[0].acc && stall)
                stalls++;
        end
        if (finished || cyc > 80000) begin
            chk("watchdog", finished, 1);
            chk("stim_timeouts", stim_to, 0);
            chk("leftover_issues", iq.size(), 0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial forever begin
        @(posedge ap_clk);
        #1 stall = stall_en && ($urandom_range(3) == 0);
    end

    task automatic launch(input int r, input int c, input bit b2b);
        bit ok = 0;
        num_rows = 16'(r);
        num_cols = 16'(c);
        ap_start = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge ap_clk);
            if (ap_idle) begin
                push_model(r, c, b2b);
                ok = 1;
            end
        end
        if (!ok) stim_to++;
        @(posedge ap_clk);
        #1 ap_start = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge ap_clk);
            ok = ap_done;
        end
        if (!ok) stim_to++;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic run(input int r, input int c);
        launch(r, c, 0);
        wait_done();
    endtask

    initial begin
        int accepts;
        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        run(2, 3);
        run(1, 1);
        run(0, 5);
        run(3, 0);
        stall_en = 1;
        run(2, 3);
        for (int k = 0; k < 20; k++) run($urandom_range(4), $urandom_range(4));
        // abort a run with reset: nothing from it may complete
        launch(4, 4, 0);
        repeat (8) @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        iq.delete();
        dq.delete();
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        run(1, 2);
        // start held across DONE: second run must be accepted on the first IDLE edge
        num_rows = 16'd1;
        num_cols = 16'd2;
        ap_start = 1'b1;
        accepts  = 0;
        for (int i = 0; i < 400 && accepts < 2; i++) begin
            @(negedge ap_clk);
            if (ap_idle && ap_start) begin
                push_model(1, 2, accepts == 1);
                accepts++;
            end
            @(posedge ap_clk);
            #1 ap_start = (accepts == 2) ? 1'b0 : (ap_done || ap_idle) ? 1'b1 : 1'($urandom_range(1));
        end
        if (accepts < 2) stim_to++;
        ap_start = 1'b0;
        wait_done();
        repeat (3) @(posedge ap_clk);
        finished = 1;
    end
endmodule
